// File: rtl/mips_datapath_register_writeback.sv
// Register-file write side: in-order result queue drained into the write port,
// plus a per-register pending-result scoreboard with busy and forwarding lookup.
package mips_datapath_register_writeback_pkg;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } Data_Control_Control_T;
endpackage

module mips_datapath_register_writeback
  import mips_datapath_register_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  Data_Control_Control_T ctrl,
  input  logic                  markValid,
  input  logic [4:0]            markAddr,
  output logic                  markReady,
  input  logic                  resValid,
  input  logic [4:0]            resAddr,
  input  logic [31:0]           resData,
  output logic                  resReady,
  input  logic                  wrHold,
  output logic                  wrEnable,
  output logic [4:0]            wrAddr,
  output logic [31:0]           wrData,
  input  logic [4:0]            rd1Addr,
  input  logic [4:0]            rd2Addr,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  fwd1Valid,
  output logic [31:0]           fwd1Data,
  output logic                  fwd2Valid,
  output logic [31:0]           fwd2Data
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  assign clk   = ctrl.clk;
  assign rst_n = ctrl.rst_n;

  logic [CNT_W-1:0] cnt_q   [32];
  logic [CNT_W-1:0] cnt_d   [32];
  logic [4:0]       qaddr_q [DEPTH];
  logic [4:0]       qaddr_d [DEPTH];
  logic [31:0]      qdata_q [DEPTH];
  logic [31:0]      qdata_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] push_idx;
  logic             wr_en_q;
  logic [4:0]       wr_addr_q;
  logic [31:0]      wr_data_q;

  logic mark_fire;
  logic res_push;
  logic pop;

  assign markReady = (cnt_q[markAddr] != '1) || (markAddr == 5'd0);
  assign resReady  = (occ_q != OCC_W'(DEPTH));
  assign mark_fire = markValid && markReady && (markAddr != 5'd0);
  assign res_push  = resValid && resReady && (resAddr != 5'd0);
  assign pop       = (occ_q != '0) && !wrHold;
  assign push_idx  = pop ? occ_q - 1'b1 : occ_q;

  assign busy1 = (rd1Addr != 5'd0) && (cnt_q[rd1Addr] != '0);
  assign busy2 = (rd2Addr != 5'd0) && (cnt_q[rd2Addr] != '0);

  assign wrEnable = wr_en_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;

  // Mark and accept to the same register cancel; accept on an empty count is absorbed.
  always_comb begin
    for (int unsigned r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (mark_fire && markAddr == 5'(r) && !(res_push && resAddr == 5'(r)))
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (res_push && resAddr == 5'(r) && !(mark_fire && markAddr == 5'(r))
               && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  // Shift queue: slot 0 is the oldest entry, slot occ_q-1 the youngest.
  always_comb begin
    qaddr_d = qaddr_q;
    qdata_d = qdata_q;
    occ_d   = occ_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        qaddr_d[i] = qaddr_q[i+1];
        qdata_d[i] = qdata_q[i+1];
      end
      occ_d = occ_q - 1'b1;
    end
    if (res_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (OCC_W'(i) == push_idx) begin
          qaddr_d[i] = resAddr;
          qdata_d[i] = resData;
        end
      end
      occ_d = occ_d + 1'b1;
    end
  end

  logic [4:0]  rd_addr [2];
  logic        fwd_v   [2];
  logic [31:0] fwd_d   [2];
  assign rd_addr[0] = rd1Addr;
  assign rd_addr[1] = rd2Addr;

  // Lowest priority first so that later (younger) matches override.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      fwd_v[p] = 1'b0;
      fwd_d[p] = '0;
      if (rd_addr[p] != 5'd0) begin
        if (wr_en_q && wr_addr_q == rd_addr[p]) begin
          fwd_v[p] = 1'b1;
          fwd_d[p] = wr_data_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (OCC_W'(i) < occ_q && qaddr_q[i] == rd_addr[p]) begin
            fwd_v[p] = 1'b1;
            fwd_d[p] = qdata_q[i];
          end
        end
      end
    end
  end

  assign fwd1Valid = fwd_v[0];
  assign fwd1Data  = fwd_d[0];
  assign fwd2Valid = fwd_v[1];
  assign fwd2Data  = fwd_d[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        qaddr_q[i] <= '0;
        qdata_q[i] <= '0;
      end
      occ_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      qaddr_q <= qaddr_d;
      qdata_q <= qdata_d;
      occ_q   <= occ_d;
      wr_en_q <= pop;
      if (pop) begin
        wr_addr_q <= qaddr_q[0];
        wr_data_q <= qdata_q[0];
      end
    end
  end

endmodule

// File: tb/tb_mips_datapath_register_writeback.sv
// Scenario bench for mips_datapath_register_writeback; register-file writes are
// checked against a queue of expected (addr, data) pairs in acceptance order.
module tb_mips_datapath_register_writeback;
  import mips_datapath_register_writeback_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  Data_Control_Control_T ctrl;
  assign ctrl = '{clk: clk, rst_n: rst_n};

  logic        markValid = 1'b0;
  logic [4:0]  markAddr = '0;
  logic        markReady;
  logic        resValid = 1'b0;
  logic [4:0]  resAddr = '0;
  logic [31:0] resData = '0;
  logic        resReady;
  logic        wrHold = 1'b0;
  logic        wrEnable;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rd1Addr = '0;
  logic [4:0]  rd2Addr = '0;
  logic        busy1, busy2, fwd1Valid, fwd2Valid;
  logic [31:0] fwd1Data, fwd2Data;

  int total = 0;
  int bad = 0;
  wr_t exp_q[$];

  mips_datapath_register_writeback #(.DEPTH(2), .CNT_W(2)) dut (
    .ctrl(ctrl), .markValid(markValid), .markAddr(markAddr), .markReady(markReady),
    .resValid(resValid), .resAddr(resAddr), .resData(resData), .resReady(resReady),
    .wrHold(wrHold), .wrEnable(wrEnable), .wrAddr(wrAddr), .wrData(wrData),
    .rd1Addr(rd1Addr), .rd2Addr(rd2Addr), .busy1(busy1), .busy2(busy2),
    .fwd1Valid(fwd1Valid), .fwd1Data(fwd1Data), .fwd2Valid(fwd2Valid), .fwd2Data(fwd2Data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

  // Write-port monitor: every write must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && wrEnable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write", wrAddr, wrData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wrAddr !== e.addr || wrData !== e.data) begin
          bad++;
          $display("FAIL write_order got addr=%0d data=%h required addr=%0d data=%h",
                   wrAddr, wrData, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    markValid = 1'b0;
    resValid  = 1'b0;
    wrHold    = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (resReady !== 1'b1 || markReady !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0 ||
        fwd1Valid !== 1'b0 || fwd2Valid !== 1'b0 || wrEnable !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rR=%b mR=%b b1=%b b2=%b f1=%b f2=%b we=%b required 1 1 0 0 0 0 0",
               resReady, markReady, busy1, busy2, fwd1Valid, fwd2Valid, wrEnable);
    end
    markValid = 1'b1; markAddr = 5'd7; rd1Addr = 5'd7;
    resValid = 1'b1; resAddr = 5'd4; resData = 32'h44; wrHold = 1'b1;
    @(negedge clk);
    markValid = 1'b0;
    resAddr = 5'd6; resData = 32'h66;
    #1;
    total++;
    if (busy1 !== 1'b1) begin
      bad++; $display("FAIL reset_pre_busy got %b required 1", busy1);
    end
    @(posedge clk);
    #1;
    total++;
    if (resReady !== 1'b0) begin
      bad++; $display("FAIL reset_pre_full got resReady=%b required 0", resReady);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (resReady !== 1'b1 || wrEnable !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got resReady=%b wrEnable=%b busy1=%b required 1 0 0",
               resReady, wrEnable, busy1);
    end
    idle();
    rd1Addr = 5'd4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (busy1 !== 1'b0 || fwd1Valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_after got busy1=%b fwd1Valid=%b pending=%0d required 0 0 0",
               busy1, fwd1Valid, exp_q.size());
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    rd1Addr = 5'd8; markValid = 1'b1; markAddr = 5'd8;
    @(negedge clk);
    markValid = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b1 || fwd1Valid !== 1'b0) begin
      bad++; $display("FAIL single_busy got busy1=%b fwd1Valid=%b required 1 0", busy1, fwd1Valid);
    end
    resValid = 1'b1; resAddr = 5'd8; resData = 32'hDEADBEEF;
    push_exp(5'd8, 32'hDEADBEEF);
    @(negedge clk);
    resValid = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0 || fwd1Valid !== 1'b1 || fwd1Data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_queued got busy1=%b fwd1Valid=%b fwd1Data=%h required 0 1 deadbeef",
               busy1, fwd1Valid, fwd1Data);
    end
    @(negedge clk);
    #1;
    total++;
    if (wrEnable !== 1'b1 || wrAddr !== 5'd8 || wrData !== 32'hDEADBEEF ||
        fwd1Valid !== 1'b1 || fwd1Data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_write got we=%b addr=%0d data=%h fwd=%b/%h required 1 8 deadbeef 1/deadbeef",
               wrEnable, wrAddr, wrData, fwd1Valid, fwd1Data);
    end
    @(negedge clk);
    #1;
    total++;
    if (fwd1Valid !== 1'b0 || fwd1Data !== 32'h0 || wrEnable !== 1'b0) begin
      bad++;
      $display("FAIL single_done got fwd1Valid=%b fwd1Data=%h we=%b required 0 0 0",
               fwd1Valid, fwd1Data, wrEnable);
    end
  endtask

  task automatic test_ordering();
    @(negedge clk);
    rd2Addr = 5'd5;
    resValid = 1'b1; resAddr = 5'd5; resData = 32'h1;
    push_exp(5'd5, 32'h1);
    @(negedge clk);
    resData = 32'h2;
    #1;
    total++;
    if (fwd2Valid !== 1'b1 || fwd2Data !== 32'h1) begin
      bad++; $display("FAIL order_first_fwd got %b/%h required 1/1", fwd2Valid, fwd2Data);
    end
    push_exp(5'd5, 32'h2);
    @(negedge clk);
    resValid = 1'b0;
    #1;
    total++;
    if (fwd2Valid !== 1'b1 || fwd2Data !== 32'h2 || wrEnable !== 1'b1 || wrData !== 32'h1) begin
      bad++;
      $display("FAIL order_youngest got fwd=%b/%h we=%b wrData=%h required 1/2 1 1",
               fwd2Valid, fwd2Data, wrEnable, wrData);
    end
    @(negedge clk);
    #1;
    total++;
    if (wrEnable !== 1'b1 || wrData !== 32'h2) begin
      bad++; $display("FAIL order_second_write got we=%b data=%h required 1 2", wrEnable, wrData);
    end
    rd2Addr = 5'd0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wrHold = 1'b1;
    resValid = 1'b1; resAddr = 5'd10; resData = 32'hA1;
    push_exp(5'd10, 32'hA1);
    @(negedge clk);
    resAddr = 5'd11; resData = 32'hA2;
    #1;
    total++;
    if (resReady !== 1'b1) begin
      bad++; $display("FAIL bp_second_ready got %b required 1", resReady);
    end
    push_exp(5'd11, 32'hA2);
    @(negedge clk);
    resAddr = 5'd12; resData = 32'hA3;
    #1;
    total++;
    if (resReady !== 1'b0) begin
      bad++; $display("FAIL bp_full got resReady=%b required 0", resReady);
    end
    @(negedge clk);
    #1;
    total++;
    if (resReady !== 1'b0 || wrEnable !== 1'b0) begin
      bad++; $display("FAIL bp_held got resReady=%b we=%b required 0 0", resReady, wrEnable);
    end
    wrHold = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (resReady !== 1'b1) begin
      bad++; $display("FAIL bp_freed got resReady=%b required 1", resReady);
    end
    push_exp(5'd12, 32'hA3);
    @(negedge clk);
    resValid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drained got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    markValid = 1'b1; markAddr = 5'd3; rd1Addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (markReady !== 1'b1) begin
        bad++; $display("FAIL sat_mark%0d got markReady=%b required 1", i, markReady);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (markReady !== 1'b0) begin
      bad++; $display("FAIL sat_full got markReady=%b required 0", markReady);
    end
    @(negedge clk);
    markValid = 1'b0;
    resValid = 1'b1; resAddr = 5'd3; resData = 32'h33;
    push_exp(5'd3, 32'h33);
    @(negedge clk);
    resValid = 1'b0;
    #1;
    total++;
    if (markReady !== 1'b1 || busy1 !== 1'b1) begin
      bad++; $display("FAIL sat_release got markReady=%b busy1=%b required 1 1", markReady, busy1);
    end
    markValid = 1'b1; markAddr = 5'd0; rd1Addr = 5'd0; rd2Addr = 5'd0;
    #1;
    total++;
    if (markReady !== 1'b1) begin
      bad++; $display("FAIL zero_mark got markReady=%b required 1", markReady);
    end
    @(negedge clk);
    markValid = 1'b0;
    resValid = 1'b1; resAddr = 5'd0; resData = 32'hFFFFFFFF;
    #1;
    total++;
    if (resReady !== 1'b1) begin
      bad++; $display("FAIL zero_res_ready got %b required 1", resReady);
    end
    @(negedge clk);
    resValid = 1'b0;
    #1;
    total++;
    if (fwd1Valid !== 1'b0 || fwd1Data !== 32'h0 || busy1 !== 1'b0 || fwd2Valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_fwd got fwd1=%b/%h busy1=%b fwd2=%b required 0/0 0 0",
               fwd1Valid, fwd1Data, busy1, fwd2Valid);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    rd1Addr = 5'd9;
    markValid = 1'b1; markAddr = 5'd9;
    @(negedge clk);
    resValid = 1'b1; resAddr = 5'd9; resData = 32'h99;
    #1;
    total++;
    if (markReady !== 1'b1 || resReady !== 1'b1 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL sim_setup got mR=%b rR=%b busy1=%b required 1 1 1", markReady, resReady, busy1);
    end
    push_exp(5'd9, 32'h99);
    @(negedge clk);
    markValid = 1'b0;
    resValid = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b1) begin
      bad++; $display("FAIL sim_count_kept got busy1=%b required 1", busy1);
    end
    resValid = 1'b1; resData = 32'h9A;
    push_exp(5'd9, 32'h9A);
    @(negedge clk);
    resData = 32'h9B;
    #1;
    total++;
    if (busy1 !== 1'b0) begin
      bad++; $display("FAIL sim_cleared got busy1=%b required 0", busy1);
    end
    push_exp(5'd9, 32'h9B);
    @(negedge clk);
    resValid = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0 || markReady !== 1'b1) begin
      bad++;
      $display("FAIL sim_no_underflow got busy1=%b markReady=%b required 0 1", busy1, markReady);
    end
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sim_drained got pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_back_to_back();
    test_saturation();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_datapath_register_writeback.md
Name: mips_datapath_register_writeback

Overview:
- Write side of the register file.
- Collects completed results from the execute/memory stages over a valid/ready handshake and buffers them in an in-order queue.
- Drains the queue one entry per cycle into the register file write port.
- Keeps a per-register pending scoreboard so that readers get stall (busy) and forwarding information for their two read addresses.

Parameters:
- DEPTH, 2, number of result queue entries (≥1).
- CNT_W, 2, width of each per-register pending counter (saturates at 2^CNT_W-1).

Ports:
- ctrl  input  Data_Control_Control_T  bundle carrying the clock and the reset; one clock; reset is asynchronous and active-low.
- markValid  input  1  decode issued an instruction writing markAddr.
- markAddr  input  5  destination register of the issued instruction.
- markReady  output  1  mark can be accepted.
- resValid  input  1  result available.
- resAddr  input  5  result destination register.
- resData  input  32  result word.
- resReady  output  1  result can be accepted.
- wrHold  input  1  suppresses the queue pop this cycle.
- wrEnable  output  1  register file write enable (registered).
- wrAddr  output  5  register file write address (registered).
- wrData  output  32  register file write data (registered).
- rd1Addr  input  5  read port 1 address.
- rd2Addr  input  5  read port 2 address.
- busy1  output  1  port 1 register has an outstanding result not yet accepted.
- busy2  output  1  port 2 register has an outstanding result not yet accepted.
- fwd1Valid  output  1  port 1 must use fwd1Data instead of register file data.
- fwd1Data  output  32  forwarded data for port 1.
- fwd2Valid  output  1  port 2 must use fwd2Data instead of register file data.
- fwd2Data  output  32  forwarded data for port 2.

Behaviour:
- Reset (asynchronous, active-low, may arrive at any time):
  - queue emptied, all counters cleared, wrEnable/wrAddr/wrData = 0.
  - Pending writes are discarded.
  - After reset: resReady=1, markReady=1, busy*=0, fwd*Valid=0.
- Mark:
  - Accepted on a clock edge when markValid && markReady; increments count[markAddr].
  - markReady = (count[markAddr] != max) || markAddr==0. It is combinational from registered counts only.
  - markAddr==0: handshake completes, no count change.
- Result:
  - Accepted on an edge when resValid && resReady.
  - resReady = queue not full. It uses the registered occupancy only; a pop in the same cycle does not free a slot.
  - Accept decrements count[resAddr]. If the count is already 0, it stays 0 (no underflow) and the entry is still enqueued.
  - resAddr==0: handshake completes, nothing enqueued, no count change.
  - Mark and accept to the same address on the same edge: count unchanged.
- Drain:
  - On each edge where the queue is non-empty at that edge and wrHold=0, the head pops into wrAddr/wrData and wrEnable=1 for the following cycle.
  - Otherwise wrEnable=0; wrAddr/wrData hold their values.
  - An entry accepted at edge N pops at edge N+1 at the earliest, giving wrEnable=1 during cycle N+1..N+2.
  - No same-edge bypass from accept to pop.
  - Entries leave in strict acceptance order.
- Busy: busyK = (rdKAddr != 0) && count[rdKAddr] != 0.
- Forwarding (combinational over registered state):
  - Search order: youngest queue entry first, then older entries, then the write-port stage (only if wrEnable=1).
  - The first entry with matching address sets fwdKValid=1 and fwdKData to that entry's data.
  - rdKAddr==0 never forwards.
  - Otherwise fwdKValid=0, fwdKData=0.
- Register 0: never written (wrEnable never asserted with wrAddr 0), never busy, never forwarded.

Test Plan:
1. Reset: enqueue two results, assert reset low mid-cycle. Required: wrEnable=0 and resReady=1 immediately (asynchronous). After release, no writes appear and busy*=0.
2. Single write to $8:
   - Mark $8 with rd1Addr=8: busy1=1.
   - Result ($8, 0xDEADBEEF) accepted at edge N: after N, busy1=0, fwd1Valid=1, fwd1Data=0xDEADBEEF.
   - During cycle N+1..N+2: wrEnable=1, wrAddr=8, wrData=0xDEADBEEF, fwd1Valid still 1.
   - Next cycle: fwd1Valid=0.
3. Ordering and youngest forward:
   - Results ($5, 0x1) then ($5, 0x2) on consecutive edges with rd2Addr=5: fwd2Data=0x2 once the second is accepted.
   - Writes appear on consecutive cycles as 0x1, then 0x2.
4. Backpressure with DEPTH=2 and wrHold=1:
   - Two accepts, then resReady=0 and a third resValid is held.
   - Release wrHold: one pop per edge, resReady=1 the cycle after the first pop, third result accepted, total three writes in order.
5. Counter saturation and register 0:
   - Mark $3 three times: markReady=0 for addr 3, a fourth mark is stalled. One result to $3 accepted: markReady=1.
   - Mark $0: no effect.
   - Result ($0, 0xFFFFFFFF): accepted, no write, fwd for rdAddr 0 stays 0.
6. Simultaneous events:
   - Mark $9 and accept result $9 on the same edge with count[9]=1: count stays 1, busy for $9 remains 1.
   - Result to $9 with count 0: no underflow, write still occurs.
